// File: rtl/al_bcd_time_counter.sv
// rtl/al_bcd_time_counter.sv - BCD time-of-day counter with 12/24h display, validated load and set-mode steps
module al_bcd_time_counter #(
   parameter bit          WITH_SECONDS = 1'b1,
   parameter logic [23:0] RESET_TIME   = 24'h120000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        mode_12h,
   input  logic [23:0] time_in,
   input  logic        load_new_time,
   input  logic        inc_hour,
   input  logic        inc_min,
   output logic [23:0] current_time_out,
   output logic        pm,
   output logic        load_error,
   output logic        day_wrap
);

   localparam logic [23:0] RESET_STATE = WITH_SECONDS ? RESET_TIME : {RESET_TIME[23:8], 8'h00};

   logic [3:0] hh_t_q, hh_u_q, mm_t_q, mm_u_q, ss_t_q, ss_u_q;
   logic [3:0] hh_t_d, hh_u_d, mm_t_d, mm_u_d, ss_t_d, ss_u_d;
   logic       load_error_q, load_error_d;
   logic       day_wrap_q, day_wrap_d;

   logic       load_valid;
   logic       carry_min;
   logic [7:0] hh_next;
   logic [8:0] mm_next, ss_next;
   logic [4:0] hour_bin, hour_12;
   logic [7:0] hh_disp;

   // Hour step with 23 -> 00 wrap.
   function automatic logic [7:0] hour_plus1(input logic [3:0] t, input logic [3:0] u);
      if (t == 4'd2 && u == 4'd3) return 8'h00;
      else if (u == 4'd9)         return {t + 4'd1, 4'd0};
      else                        return {t, u + 4'd1};
   endfunction

   // Modulo-60 step; MSB flags the 59 -> 00 roll.
   function automatic logic [8:0] sixty_plus1(input logic [3:0] t, input logic [3:0] u);
      if (u == 4'd9) begin
         if (t == 4'd5) return 9'h100;
         else           return {1'b0, t + 4'd1, 4'd0};
      end else begin
         return {1'b0, t, u + 4'd1};
      end
   endfunction

   assign hh_next = hour_plus1(hh_t_q, hh_u_q);
   assign mm_next = sixty_plus1(mm_t_q, mm_u_q);
   assign ss_next = sixty_plus1(ss_t_q, ss_u_q);

   assign load_valid = (time_in[23:20] <= 4'd2) && (time_in[19:16] <= 4'd9) &&
                       (time_in[23:16] <= 8'h23) &&
                       (time_in[15:12] <= 4'd5) && (time_in[11:8] <= 4'd9) &&
                       (!WITH_SECONDS || ((time_in[7:4] <= 4'd5) && (time_in[3:0] <= 4'd9)));

   always_comb begin
      hh_t_d       = hh_t_q;
      hh_u_d       = hh_u_q;
      mm_t_d       = mm_t_q;
      mm_u_d       = mm_u_q;
      ss_t_d       = ss_t_q;
      ss_u_d       = ss_u_q;
      load_error_d = 1'b0;
      day_wrap_d   = 1'b0;
      carry_min    = 1'b0;
      if (load_new_time) begin
         if (load_valid) begin
            {hh_t_d, hh_u_d, mm_t_d, mm_u_d} = time_in[23:8];
            {ss_t_d, ss_u_d} = WITH_SECONDS ? time_in[7:0] : 8'h00;
         end else begin
            load_error_d = 1'b1;
         end
      end else if (inc_hour || inc_min) begin
         if (inc_min)  {mm_t_d, mm_u_d} = mm_next[7:0];
         if (inc_hour) {hh_t_d, hh_u_d} = hh_next;
      end else if (tick) begin
         // Without seconds the tick enters directly at the minutes digit.
         if (WITH_SECONDS) begin
            {ss_t_d, ss_u_d} = ss_next[7:0];
            carry_min = ss_next[8];
         end else begin
            carry_min = 1'b1;
         end
         if (carry_min) begin
            {mm_t_d, mm_u_d} = mm_next[7:0];
            if (mm_next[8]) begin
               {hh_t_d, hh_u_d} = hh_next;
               day_wrap_d = (hh_next == 8'h00);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         {hh_t_q, hh_u_q, mm_t_q, mm_u_q, ss_t_q, ss_u_q} <= RESET_STATE;
         load_error_q <= 1'b0;
         day_wrap_q   <= 1'b0;
      end else begin
         {hh_t_q, hh_u_q, mm_t_q, mm_u_q, ss_t_q, ss_u_q} <=
            {hh_t_d, hh_u_d, mm_t_d, mm_u_d, ss_t_d, ss_u_d};
         load_error_q <= load_error_d;
         day_wrap_q   <= day_wrap_d;
      end
   end

   always_comb begin
      hour_bin = {1'b0, hh_t_q} * 5'd10 + {1'b0, hh_u_q};
      if (hour_bin == 5'd0)       hour_12 = 5'd12;
      else if (hour_bin > 5'd12)  hour_12 = hour_bin - 5'd12;
      else                        hour_12 = hour_bin;
      if (!mode_12h)              hh_disp = {hh_t_q, hh_u_q};
      else if (hour_12 >= 5'd10)  hh_disp = {4'd1, 4'(hour_12 - 5'd10)};
      else                        hh_disp = {4'd0, hour_12[3:0]};
   end

   assign current_time_out = {hh_disp, mm_t_q, mm_u_q, ss_t_q, ss_u_q};
   assign pm               = (hour_bin >= 5'd12);
   assign load_error       = load_error_q;
   assign day_wrap         = day_wrap_q;

endmodule

// File: tb/tb_al_bcd_time_counter.sv
// tb/tb_al_bcd_time_counter.sv - randomized self-checking bench for al_bcd_time_counter
module tb_al_bcd_time_counter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick = 1'b0;
   logic        mode_12h = 1'b0;
   logic [23:0] time_in = 24'h0;
   logic        load_new_time = 1'b0;
   logic        inc_hour = 1'b0;
   logic        inc_min = 1'b0;
   logic [23:0] current_time_out;
   logic        pm;
   logic        load_error;
   logic        day_wrap;

   int errors = 0;
   int checks = 0;

   // Reference model: time of day as seconds since midnight.
   int m_secs = 43200;
   bit m_lerr = 0;
   bit m_dw = 0;

   al_bcd_time_counter dut (
      .clk(clk), .reset(reset), .tick(tick), .mode_12h(mode_12h),
      .time_in(time_in), .load_new_time(load_new_time),
      .inc_hour(inc_hour), .inc_min(inc_min),
      .current_time_out(current_time_out), .pm(pm),
      .load_error(load_error), .day_wrap(day_wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] bcd2(input int x);
      return 8'(((x / 10) << 4) | (x % 10));
   endfunction

   function automatic logic [23:0] secs_to_bcd(input int s);
      return {bcd2(s / 3600), bcd2((s / 60) % 60), bcd2(s % 60)};
   endfunction

   function automatic int dig(input logic [23:0] t, input int idx);
      return int'((t >> (4 * idx)) & 24'hF);
   endfunction

   function automatic bit time_valid(input logic [23:0] t);
      int h;
      h = dig(t, 5) * 10 + dig(t, 4);
      return dig(t, 5) <= 2 && dig(t, 4) <= 9 && h <= 23 && dig(t, 3) <= 5 &&
             dig(t, 2) <= 9 && dig(t, 1) <= 5 && dig(t, 0) <= 9;
   endfunction

   function automatic int bcd_to_secs(input logic [23:0] t);
      return (dig(t, 5) * 10 + dig(t, 4)) * 3600 + (dig(t, 3) * 10 + dig(t, 2)) * 60 +
             dig(t, 1) * 10 + dig(t, 0);
   endfunction

   function automatic logic [23:0] exp_out(input int s, input bit m12);
      int h;
      h = s / 3600;
      if (m12) h = (h % 12 == 0) ? 12 : h % 12;
      return {bcd2(h), bcd2((s / 60) % 60), bcd2(s % 60)};
   endfunction

   // Drive one cycle of requests, advance the model, land 1 time unit after the edge.
   task automatic cycle(input bit ld, input logic [23:0] tin, input bit ih, input bit im, input bit tk);
      int h, m, s;
      load_new_time = ld; time_in = tin; inc_hour = ih; inc_min = im; tick = tk;
      @(posedge clk);
      #1;
      load_new_time = 0; inc_hour = 0; inc_min = 0; tick = 0;
      m_lerr = 0;
      m_dw = 0;
      if (ld) begin
         if (time_valid(tin)) m_secs = bcd_to_secs(tin);
         else m_lerr = 1;
      end else if (ih || im) begin
         h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
         if (im) m = (m + 1) % 60;
         if (ih) h = (h + 1) % 24;
         m_secs = h * 3600 + m * 60 + s;
      end else if (tk) begin
         if (m_secs == 86399) m_dw = 1;
         m_secs = (m_secs + 1) % 86400;
      end
   endtask

   task automatic test_reset;
      reset = 0; mode_12h = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (current_time_out !== 24'h120000) begin errors++; $display("FAIL reset_out got %h want %h", current_time_out, 24'h120000); end
      checks++; if (pm !== 1'b1) begin errors++; $display("FAIL reset_pm got %b want 1", pm); end
      checks++; if (load_error !== 1'b0 || day_wrap !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", load_error, day_wrap); end
      mode_12h = 1; #1;
      checks++; if (current_time_out !== 24'h120000) begin errors++; $display("FAIL reset_12h_out got %h want %h", current_time_out, 24'h120000); end
      mode_12h = 0;
      reset = 1;
      m_secs = 43200; m_lerr = 0; m_dw = 0;
      cycle(0, 0, 0, 0, 0);
   endtask

   task automatic test_day_wrap;
      cycle(1, 24'h235958, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      checks++; if (current_time_out !== 24'h235959) begin errors++; $display("FAIL wrap_tick1 got %h want %h", current_time_out, 24'h235959); end
      checks++; if (pm !== 1'b1) begin errors++; $display("FAIL wrap_pm_before got %b want 1", pm); end
      cycle(0, 0, 0, 0, 1);
      checks++; if (current_time_out !== 24'h000000) begin errors++; $display("FAIL wrap_tick2 got %h want %h", current_time_out, 24'h000000); end
      checks++; if (day_wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %b want 1", day_wrap); end
      checks++; if (pm !== 1'b0) begin errors++; $display("FAIL wrap_pm_after got %b want 0", pm); end
      cycle(0, 0, 0, 0, 0);
      checks++; if (day_wrap !== 1'b0) begin errors++; $display("FAIL wrap_pulse_len got %b want 0", day_wrap); end
   endtask

   task automatic test_load_error;
      cycle(1, 24'h101010, 0, 0, 0);
      cycle(1, 24'h246000, 0, 0, 0);
      checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL lerr_pulse got %b want 1", load_error); end
      checks++; if (current_time_out !== 24'h101010) begin errors++; $display("FAIL lerr_state got %h want %h", current_time_out, 24'h101010); end
      cycle(0, 0, 0, 0, 0);
      checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL lerr_len got %b want 0", load_error); end
      cycle(1, 24'h095960, 0, 0, 0);
      checks++; if (load_error !== 1'b1 || current_time_out !== 24'h101010) begin errors++; $display("FAIL lerr_secs got %b/%h want 1/%h", load_error, current_time_out, 24'h101010); end
   endtask

   task automatic test_mode_12h;
      mode_12h = 1;
      cycle(1, 24'h225930, 0, 0, 0);
      checks++; if (current_time_out !== 24'h105930 || pm !== 1'b1) begin errors++; $display("FAIL m12_22h got %h/%b want %h/1", current_time_out, pm, 24'h105930); end
      cycle(1, 24'h003000, 0, 0, 0);
      checks++; if (current_time_out !== 24'h123000 || pm !== 1'b0) begin errors++; $display("FAIL m12_00h got %h/%b want %h/0", current_time_out, pm, 24'h123000); end
      mode_12h = 0; #1;
      checks++; if (current_time_out !== 24'h003000) begin errors++; $display("FAIL m12_toggle got %h want %h", current_time_out, 24'h003000); end
   endtask

   task automatic test_steps;
      cycle(1, 24'h235930, 0, 0, 0);
      cycle(0, 0, 0, 1, 0);
      checks++; if (current_time_out !== 24'h230030) begin errors++; $display("FAIL step_min got %h want %h", current_time_out, 24'h230030); end
      cycle(0, 0, 1, 0, 0);
      checks++; if (current_time_out !== 24'h000030 || day_wrap !== 1'b0) begin errors++; $display("FAIL step_hour got %h/%b want %h/0", current_time_out, day_wrap, 24'h000030); end
      cycle(1, 24'h105900, 0, 0, 0);
      cycle(0, 0, 1, 1, 0);
      checks++; if (current_time_out !== 24'h110000) begin errors++; $display("FAIL step_both got %h want %h", current_time_out, 24'h110000); end
   endtask

   task automatic test_priority;
      cycle(1, 24'h081500, 1, 0, 1);
      checks++; if (current_time_out !== 24'h081500) begin errors++; $display("FAIL prio_load got %h want %h", current_time_out, 24'h081500); end
      cycle(0, 0, 0, 1, 1);
      checks++; if (current_time_out !== 24'h081600) begin errors++; $display("FAIL prio_step got %h want %h", current_time_out, 24'h081600); end
   endtask

   task automatic test_back_to_back;
      cycle(1, 24'h235957, 0, 0, 0);
      tick = 1;
      repeat (3) @(posedge clk);
      #1; tick = 0;
      m_secs = 0;
      checks++; if (current_time_out !== secs_to_bcd(m_secs) || day_wrap !== 1'b1) begin errors++; $display("FAIL held_tick got %h/%b want %h/1", current_time_out, day_wrap, secs_to_bcd(m_secs)); end
   endtask

   task automatic test_random;
      logic [23:0] tin;
      int r;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 19);
         tin = (r == 0) ? 24'($urandom) : secs_to_bcd(int'($urandom_range(0, 86399)));
         if ($urandom_range(0, 49) == 0) tin = secs_to_bcd(86398);
         mode_12h = $urandom_range(0, 1);
         cycle(r < 2, tin, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 3) != 0);
         checks++; if (current_time_out !== exp_out(m_secs, mode_12h)) begin errors++; $display("FAIL rnd_out[%0d] got %h want %h", i, current_time_out, exp_out(m_secs, mode_12h)); end
         checks++; if (pm !== (m_secs >= 43200)) begin errors++; $display("FAIL rnd_pm[%0d] got %b want %b", i, pm, m_secs >= 43200); end
         checks++; if (load_error !== m_lerr) begin errors++; $display("FAIL rnd_lerr[%0d] got %b want %b", i, load_error, m_lerr); end
         checks++; if (day_wrap !== m_dw) begin errors++; $display("FAIL rnd_wrap[%0d] got %b want %b", i, day_wrap, m_dw); end
      end
      mode_12h = 0;
   endtask

   task automatic test_reset_mid;
      cycle(1, 24'h235959, 0, 0, 0);
      tick = 1;
      #2 reset = 0;
      #1;
      checks++; if (current_time_out !== 24'h120000 || day_wrap !== 1'b0) begin errors++; $display("FAIL rst_async got %h/%b want %h/0", current_time_out, day_wrap, 24'h120000); end
      @(posedge clk); #1;
      tick = 0;
      checks++; if (current_time_out !== 24'h120000 || day_wrap !== 1'b0) begin errors++; $display("FAIL rst_hold got %h/%b want %h/0", current_time_out, day_wrap, 24'h120000); end
      reset = 1;
      m_secs = 43200;
      cycle(0, 0, 0, 0, 1);
      checks++; if (current_time_out !== 24'h120001) begin errors++; $display("FAIL rst_resume got %h want %h", current_time_out, 24'h120001); end
   endtask

   initial begin
      test_reset();
      test_day_wrap();
      test_load_error();
      test_mode_12h();
      test_steps();
      test_priority();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
